pulse_train_ctrl: RTL and testbench



---
 rtl/pulse_train_ctrl_pkg.sv | 12 +
 rtl/pulse_train_ctrl_phase_counter.sv | 38 +++
 rtl/pulse_train_ctrl.sv | 131 +++++++++++++
 tb/tb_pulse_train_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_ctrl_pkg.sv
// Shared types and defaults for the programmable pulse-train controller.
package pulse_train_ctrl_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_train_ctrl_phase_counter.sv
// Phase counter for one pulse period: counts 0..term_i, flags the terminal cycle.
module pulse_train_ctrl_phase_counter
   import pulse_train_ctrl_pkg::*;
#(
   parameter int unsigned Width = DefaultWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] term_i,
   output logic [Width-1:0] phase_o,
   output logic             wrap_o
);

   logic [Width-1:0] phase_q, phase_d;

   assign wrap_o  = (phase_q == term_i);
   assign phase_o = phase_q;

   always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
         phase_d = '0;
      end else if (en_i) begin
         phase_d = wrap_o ? '0 : phase_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/pulse_train_ctrl.sv
// Programmable pulse-train scheduler: latches period/high time/count on start and
// emits a registered waveform for count periods (or until stop when count is 0).
module pulse_train_ctrl
   import pulse_train_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] high_time,
   input  logic [WIDTH-1:0] count,
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] pulses_left
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] left_q, left_d;
   logic             pulse_q, pulse_d;

   logic             phase_clr, phase_en, phase_wrap;
   logic [WIDTH-1:0] phase, phase_inc, high_clamp, term;

   assign high_clamp = (high_time > period) ? period : high_time;
   assign phase_inc  = phase + WIDTH'(1);
   assign term       = per_q - WIDTH'(1);

   pulse_train_ctrl_phase_counter #(
      .Width (WIDTH)
   ) u_phase_counter (
      .clk_i   (clock),
      .rst_i   (reset),
      .clr_i   (phase_clr),
      .en_i    (phase_en),
      .term_i  (term),
      .phase_o (phase),
      .wrap_o  (phase_wrap)
   );

   always_comb begin
      state_d   = state_q;
      per_d     = per_q;
      high_d    = high_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      pulse_d   = pulse_q;
      phase_clr = 1'b0;
      phase_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            pulse_d   = 1'b0;
            left_d    = '0;
            phase_clr = 1'b1;
            if (start && !stop && (period != '0)) begin
               state_d = StRun;
               per_d   = period;
               high_d  = high_clamp;
               cnt_d   = count;
               left_d  = count;
               pulse_d = (high_clamp != '0);
            end
         end
         StRun: begin
            // stop wins over the wrap/done decision in the same cycle
            if (stop) begin
               state_d   = StIdle;
               pulse_d   = 1'b0;
               left_d    = '0;
               phase_clr = 1'b1;
            end else begin
               phase_en = 1'b1;
               if (phase_wrap) begin
                  if ((cnt_q != '0) && (left_q == WIDTH'(1))) begin
                     state_d = StDone;
                     pulse_d = 1'b0;
                     left_d  = '0;
                  end else begin
                     if (cnt_q != '0) begin
                        left_d = left_q - WIDTH'(1);
                     end
                     pulse_d = (high_q != '0);
                  end
               end else begin
                  pulse_d = (phase_inc < high_q);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            pulse_d = 1'b0;
            left_d  = '0;
         end
         default: begin
            state_d = StIdle;
            pulse_d = 1'b0;
            left_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         per_q   <= '0;
         high_q  <= '0;
         cnt_q   <= '0;
         left_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         high_q  <= high_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse       = pulse_q;
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign pulses_left = left_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: per-cycle vector table with a scoreboard queue.
module tb_pulse_train_ctrl;

   typedef struct {
      string      name;
      int         cyc;
      logic       start;
      logic       stop;
      logic [7:0] per;
      logic [7:0] ht;
      logic [7:0] cnt;
      logic       e_pulse;
      logic       e_busy;
      logic       e_done;
      logic [7:0] e_left;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic [7:0] period;
   logic [7:0] high_time;
   logic [7:0] count;
   logic       pulse;
   logic       busy;
   logic       done;
   logic [7:0] pulses_left;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clock = ~clock;

   pulse_train_ctrl #(
      .WIDTH (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .period      (period),
      .high_time   (high_time),
      .count       (count),
      .pulse       (pulse),
      .busy        (busy),
      .done        (done),
      .pulses_left (pulses_left)
   );

   function automatic vec_t mk(string name, int cyc, int st, int sp, int p, int h, int n,
                               int ep, int eb, int ed, int el);
      vec_t v;
      v.name    = name;
      v.cyc     = cyc;
      v.start   = 1'(st);
      v.stop    = 1'(sp);
      v.per     = 8'(p);
      v.ht      = 8'(h);
      v.cnt     = 8'(n);
      v.e_pulse = 1'(ep);
      v.e_busy  = 1'(eb);
      v.e_done  = 1'(ed);
      v.e_left  = 8'(el);
      return v;
   endfunction

   task automatic check1(string name, int cyc, string what, logic [7:0] got, logic [7:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc%0d %s: got %0d want %0d", name, cyc, what, got, want);
      end
   endtask

   task automatic check_outputs(string name, int cyc, logic ep, logic eb, logic ed,
                                logic [7:0] el);
      check1(name, cyc, "pulse", {7'b0, pulse}, {7'b0, ep});
      check1(name, cyc, "busy", {7'b0, busy}, {7'b0, eb});
      check1(name, cyc, "done", {7'b0, done}, {7'b0, ed});
      check1(name, cyc, "pulses_left", pulses_left, el);
   endtask

   task automatic check_pending();
      vec_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_outputs(e.name, e.cyc, e.e_pulse, e.e_busy, e.e_done, e.e_left);
      end
   endtask

   // Inputs for edge N are driven at the preceding negedge; the expectation is the
   // state right after edge N and is checked at the following negedge.
   task automatic apply(vec_t v);
      @(negedge clock);
      check_pending();
      start     = v.start;
      stop      = v.stop;
      period    = v.per;
      high_time = v.ht;
      count     = v.cnt;
      exp_q.push_back(v);
   endtask

   task automatic flush();
      @(negedge clock);
      check_pending();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      period    = 8'd0;
      high_time = 8'd0;
      count     = 8'd0;

      // 1: P=4 H=1 N=3
      tbl.push_back(mk("t1", 0, 1, 0, 4, 1, 3, 1, 1, 0, 3));
      for (int c = 1; c < 12; c++)
         tbl.push_back(mk("t1", c, 0, 0, 4, 1, 3, int'((c % 4) == 0), 1, 0, 3 - c / 4));
      tbl.push_back(mk("t1", 12, 0, 0, 4, 1, 3, 0, 0, 1, 0));
      tbl.push_back(mk("t1", 13, 0, 0, 4, 1, 3, 0, 0, 0, 0));

      // 2: P=5 H=9 (clamped) N=2, then H=0
      tbl.push_back(mk("t2a", 0, 1, 0, 5, 9, 2, 1, 1, 0, 2));
      for (int c = 1; c < 10; c++)
         tbl.push_back(mk("t2a", c, 0, 0, 5, 9, 2, 1, 1, 0, (c < 5) ? 2 : 1));
      tbl.push_back(mk("t2a", 10, 0, 0, 5, 9, 2, 0, 0, 1, 0));
      tbl.push_back(mk("t2a", 11, 0, 0, 5, 9, 2, 0, 0, 0, 0));
      tbl.push_back(mk("t2b", 0, 1, 0, 5, 0, 2, 0, 1, 0, 2));
      for (int c = 1; c < 10; c++)
         tbl.push_back(mk("t2b", c, 0, 0, 5, 0, 2, 0, 1, 0, (c < 5) ? 2 : 1));
      tbl.push_back(mk("t2b", 10, 0, 0, 5, 0, 2, 0, 0, 1, 0));
      tbl.push_back(mk("t2b", 11, 0, 0, 5, 0, 2, 0, 0, 0, 0));

      // 3: P=3 H=2 continuous, stop during cycle 7
      tbl.push_back(mk("t3", 0, 1, 0, 3, 2, 0, 1, 1, 0, 0));
      for (int c = 1; c < 8; c++)
         tbl.push_back(mk("t3", c, 0, 0, 3, 2, 0, int'((c % 3) < 2), 1, 0, 0));
      tbl.push_back(mk("t3", 8, 0, 1, 3, 2, 0, 0, 0, 0, 0));
      tbl.push_back(mk("t3", 9, 0, 0, 3, 2, 0, 0, 0, 0, 0));

      // 4: illegal period, start+stop together, then start ignored in RUN/DONE
      tbl.push_back(mk("t4p0", 0, 1, 0, 0, 2, 2, 0, 0, 0, 0));
      tbl.push_back(mk("t4ss", 0, 1, 1, 4, 2, 2, 0, 0, 0, 0));
      tbl.push_back(mk("t4ss", 1, 0, 0, 4, 2, 2, 0, 0, 0, 0));
      tbl.push_back(mk("t4run", 0, 1, 0, 4, 2, 2, 1, 1, 0, 2));
      tbl.push_back(mk("t4run", 1, 1, 0, 7, 7, 9, 1, 1, 0, 2));
      tbl.push_back(mk("t4run", 2, 0, 0, 7, 7, 9, 0, 1, 0, 2));
      tbl.push_back(mk("t4run", 3, 1, 0, 7, 7, 9, 0, 1, 0, 2));
      tbl.push_back(mk("t4run", 4, 0, 0, 7, 7, 9, 1, 1, 0, 1));
      tbl.push_back(mk("t4run", 5, 0, 0, 7, 7, 9, 1, 1, 0, 1));
      tbl.push_back(mk("t4run", 6, 0, 0, 7, 7, 9, 0, 1, 0, 1));
      tbl.push_back(mk("t4run", 7, 0, 0, 7, 7, 9, 0, 1, 0, 1));
      tbl.push_back(mk("t4run", 8, 1, 0, 7, 7, 9, 0, 0, 1, 0));
      tbl.push_back(mk("t4run", 9, 1, 0, 7, 7, 9, 0, 0, 0, 0));
      tbl.push_back(mk("t4run", 10, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // 6: P=1 H=1 N=4, then stop in the final wrap cycle
      tbl.push_back(mk("t6", 0, 1, 0, 1, 1, 4, 1, 1, 0, 4));
      for (int c = 1; c < 4; c++)
         tbl.push_back(mk("t6", c, 0, 0, 1, 1, 4, 1, 1, 0, 4 - c));
      tbl.push_back(mk("t6", 4, 0, 0, 1, 1, 4, 0, 0, 1, 0));
      tbl.push_back(mk("t6", 5, 0, 0, 1, 1, 4, 0, 0, 0, 0));
      tbl.push_back(mk("t6s", 0, 1, 0, 1, 1, 4, 1, 1, 0, 4));
      for (int c = 1; c < 4; c++)
         tbl.push_back(mk("t6s", c, 0, 0, 1, 1, 4, 1, 1, 0, 4 - c));
      tbl.push_back(mk("t6s", 4, 0, 1, 1, 1, 4, 0, 0, 0, 0));
      tbl.push_back(mk("t6s", 5, 0, 0, 1, 1, 4, 0, 0, 0, 0));

      repeat (2) @(negedge clock);
      check_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);
      flush();

      // 5: asynchronous reset mid-RUN while pulse is high, then a fresh train
      apply(mk("t5", 0, 1, 0, 6, 3, 4, 1, 1, 0, 4));
      apply(mk("t5", 1, 0, 0, 6, 3, 4, 1, 1, 0, 4));
      flush();
      @(posedge clock);
      #2;
      check_outputs("t5pre", 2, 1'b1, 1'b1, 1'b0, 8'd4);
      reset = 1'b1;
      #1;
      check_outputs("t5rst", 2, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clock);
      check_outputs("t5hold", 3, 1'b0, 1'b0, 1'b0, 8'd0);
      reset = 1'b0;
      apply(mk("t5new", 0, 1, 0, 2, 1, 2, 1, 1, 0, 2));
      apply(mk("t5new", 1, 0, 0, 2, 1, 2, 0, 1, 0, 2));
      apply(mk("t5new", 2, 0, 0, 2, 1, 2, 1, 1, 0, 1));
      apply(mk("t5new", 3, 0, 0, 2, 1, 2, 0, 1, 0, 1));
      apply(mk("t5new", 4, 0, 0, 2, 1, 2, 0, 0, 1, 0));
      apply(mk("t5new", 5, 0, 0, 2, 1, 2, 0, 0, 0, 0));
      flush();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
